// File: rtl/alu_op_sequencer.sv
// ----------------------------------------------------------------------------
// alu_op_sequencer
//
// Multi-cycle control sequencer for the shared 32-bit bus datapath: register
// file, Y latch, ALU, 64-bit Z register and HI/LO. It accepts one ALU
// instruction at a time and issues the register-out, Y-in, ALU-opcode, Z-in,
// Z-out and destination-in strobes in order.
//
// Ports:
//   clk, clr             clock (rising edge), synchronous active-high reset
//   op_valid / op_ready  instruction handshake; op_ready only in IDLE
//   opcode_in, ra_in,
//   rb_in, rd_in         instruction fields, latched on accept
//   reg_sel              register-file select for bus read or write
//   r_out / r_in         selected register drives / latches bus
//   y_in                 Y latches bus
//   alu_op               opcode presented to the ALU
//   z_in                 Z latches the 64-bit ALU result
//   zlo_out / zhi_out    Z[31:0] / Z[63:32] drives bus
//   lo_in / hi_in        LO / HI latch bus
//   done                 one-cycle pulse in the final writeback cycle
//   illegal              one-cycle pulse for an unsupported opcode
// ----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int unsigned MULDIV_LAT = 1,
    parameter int unsigned REG_SEL_W  = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [4:0]           opcode_in,
    input  logic [REG_SEL_W-1:0] ra_in,
    input  logic [REG_SEL_W-1:0] rb_in,
    input  logic [REG_SEL_W-1:0] rd_in,
    output logic [REG_SEL_W-1:0] reg_sel,
    output logic                 r_out,
    output logic                 r_in,
    output logic                 y_in,
    output logic [4:0]           alu_op,
    output logic                 z_in,
    output logic                 zlo_out,
    output logic                 zhi_out,
    output logic                 lo_in,
    output logic                 hi_in,
    output logic                 done,
    output logic                 illegal
);

    typedef enum logic [2:0] {
        StIdle,
        StIll,
        StLoadA,
        StExec,
        StWbLo,
        StWbHi
    } state_e;

    // EXEC holds until the counter reaches zero; mul/div preload LAT-1.
    localparam logic [3:0] LastCnt = 4'(MULDIV_LAT - 1);

    function automatic logic is_binary(input logic [4:0] opc);
        return opc inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                           5'b01000, 5'b01001, 5'b01010, 5'b01011};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] opc);
        return opc inside {5'b01111, 5'b10000};
    endfunction

    function automatic logic is_unary(input logic [4:0] opc);
        return opc inside {5'b10001, 5'b10010};
    endfunction

    state_e               state_q, state_d;
    logic [4:0]           opc_q, opc_d;
    logic [REG_SEL_W-1:0] ra_q, ra_d;
    logic [REG_SEL_W-1:0] rb_q, rb_d;
    logic [REG_SEL_W-1:0] rd_q, rd_d;
    logic [3:0]           cnt_q, cnt_d;

    // Next-cycle output values, decoded from next state and next fields so
    // every output leaves a flop.
    logic                 op_ready_d;
    logic [REG_SEL_W-1:0] reg_sel_d;
    logic                 r_out_d, r_in_d, y_in_d;
    logic [4:0]           alu_op_d;
    logic                 z_in_d, zlo_out_d, zhi_out_d;
    logic                 lo_in_d, hi_in_d, done_d, illegal_d;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (op_valid) begin
                    opc_d = opcode_in;
                    ra_d  = ra_in;
                    rb_d  = rb_in;
                    rd_d  = rd_in;
                    if (is_binary(opcode_in) || is_muldiv(opcode_in)) begin
                        state_d = StLoadA;
                    end else if (is_unary(opcode_in)) begin
                        state_d = StExec;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StIll;
                    end
                end
            end
            StIll:   state_d = StIdle;
            StLoadA: begin
                state_d = StExec;
                cnt_d   = is_muldiv(opc_q) ? LastCnt : 4'd0;
            end
            StExec: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWbLo;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWbLo:  state_d = is_muldiv(opc_q) ? StWbHi : StIdle;
            StWbHi:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode for the upcoming state
    always_comb begin
        op_ready_d = (state_d == StIdle);
        reg_sel_d  = '0;
        r_out_d    = 1'b0;
        r_in_d     = 1'b0;
        y_in_d     = 1'b0;
        alu_op_d   = 5'd0;
        z_in_d     = 1'b0;
        zlo_out_d  = 1'b0;
        zhi_out_d  = 1'b0;
        lo_in_d    = 1'b0;
        hi_in_d    = 1'b0;
        done_d     = 1'b0;
        illegal_d  = 1'b0;
        case (state_d)
            StIll: illegal_d = 1'b1;
            StLoadA: begin
                reg_sel_d = ra_d;
                r_out_d   = 1'b1;
                y_in_d    = 1'b1;
            end
            StExec: begin
                // Unary ops read their only operand from ra.
                reg_sel_d = is_unary(opc_d) ? ra_d : rb_d;
                r_out_d   = 1'b1;
                alu_op_d  = opc_d;
                z_in_d    = (cnt_d == 4'd0);
            end
            StWbLo: begin
                zlo_out_d = 1'b1;
                if (is_muldiv(opc_d)) begin
                    lo_in_d = 1'b1;
                end else begin
                    reg_sel_d = rd_d;
                    r_in_d    = 1'b1;
                    done_d    = 1'b1;
                end
            end
            StWbHi: begin
                zhi_out_d = 1'b1;
                hi_in_d   = 1'b1;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= StIdle;
            opc_q    <= 5'd0;
            ra_q     <= '0;
            rb_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= 4'd0;
            op_ready <= 1'b1;
            reg_sel  <= '0;
            r_out    <= 1'b0;
            r_in     <= 1'b0;
            y_in     <= 1'b0;
            alu_op   <= 5'd0;
            z_in     <= 1'b0;
            zlo_out  <= 1'b0;
            zhi_out  <= 1'b0;
            lo_in    <= 1'b0;
            hi_in    <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            op_ready <= op_ready_d;
            reg_sel  <= reg_sel_d;
            r_out    <= r_out_d;
            r_in     <= r_in_d;
            y_in     <= y_in_d;
            alu_op   <= alu_op_d;
            z_in     <= z_in_d;
            zlo_out  <= zlo_out_d;
            zhi_out  <= zhi_out_d;
            lo_in    <= lo_in_d;
            hi_in    <= hi_in_d;
            done     <= done_d;
            illegal  <= illegal_d;
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control sequencer for the shared 32-bit bus datapath: register file, Y latch, ALU, 64-bit Z register, and the HI/LO registers.
- Accepts one ALU instruction at a time through a valid/ready handshake.
- Issues, in order, the register-out, Y-in, ALU-opcode, Z-in, Z-out and destination-in strobes needed to execute that instruction.
- Owns the ALU opcode encoding and the stall timing for MUL/DIV.

Parameters:
MULDIV_LAT, 1, cycles the EXEC state is held for opcodes 01111/10000 (legal range 1..15)
REG_SEL_W, 4, width of register-file select fields

Ports:
clk  in  1  system clock, rising edge
clr  in  1  reset, synchronous, active-high
op_valid  in  1  instruction request
op_ready  out  1  sequencer can accept; high only in IDLE
opcode_in  in  5  ALU opcode
ra_in  in  REG_SEL_W  source A register
rb_in  in  REG_SEL_W  source B register
rd_in  in  REG_SEL_W  destination register
reg_sel  out  REG_SEL_W  register-file select for bus read or write
r_out  out  1  selected register drives bus
r_in  out  1  selected register latches bus
y_in  out  1  Y latches bus
alu_op  out  5  opcode to ALU
z_in  out  1  Z latches 64-bit ALU result
zlo_out  out  1  Z[31:0] drives bus
zhi_out  out  1  Z[63:32] drives bus
lo_in  out  1  LO latches bus
hi_in  out  1  HI latches bus
done  out  1  one-cycle pulse in final writeback cycle
illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Legal opcodes:
  - binary: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011
  - mul/div: MUL 01111, DIV 10000
  - unary: NEG 10001, NOT 10010
  - All other codes are illegal.
- Reset: when clr=1 at a rising edge, state←IDLE and every output except op_ready is 0 next cycle, from any state. No partial write completes. Handshake is ignored while clr=1.
- All strobes, reg_sel and alu_op decode from registered state and latched fields only; there is no combinational path from inputs to outputs. op_ready=(state==IDLE).
- Accept: op_valid&op_ready at an edge latches opcode/ra/rb/rd. Input changes after acceptance have no effect.
- States and outputs:
  - IDLE: outputs 0, alu_op=0.
    - Accept binary or mul/div → LOADA.
    - Accept unary → EXEC.
    - Accept illegal → ILL.
  - ILL: illegal=1 for one cycle → IDLE. No bus or register strobes.
  - LOADA: reg_sel=ra, r_out=1, y_in=1 → EXEC.
  - EXEC:
    - Source selection: reg_sel=rb, or ra for unary; r_out=1.
    - alu_op = latched opcode.
    - Non-mul/div: z_in=1 → WBLO.
    - Mul/div: a counter holds EXEC for MULDIV_LAT cycles. z_in=1 only in the last EXEC cycle. alu_op/reg_sel/r_out stay stable throughout.
  - WBLO: zlo_out=1.
    - Non-mul/div: reg_sel=rd, r_in=1, done=1 → IDLE.
    - Mul/div: lo_in=1 → WBHI.
  - WBHI: zhi_out=1, hi_in=1, done=1 → IDLE.
- Latency, accept edge to done cycle:
  - binary: 3 cycles
  - unary: 2 cycles
  - mul/div: 3+MULDIV_LAT cycles
  - illegal: illegal pulses 1 cycle after accept.
- Back-to-back: the cycle after done (or illegal) is IDLE with op_ready=1. With op_valid held high, the next instruction is accepted in that IDLE cycle. Throughput is one instruction per latency+1 cycles.
- Mutual exclusion: r_out and zlo_out/zhi_out are never both 1. At most one bus driver per cycle. r_in/lo_in/hi_in are never simultaneous.
- Divide-by-zero and ALU data values are outside this block.
- rd=ra or rd=rb is permitted. The write occurs after both reads.

Test Plan:
- ADD, ra=1, rb=2, rd=3, accept at cycle 0. Required response:
  - cycle 1: reg_sel=1, r_out, y_in.
  - cycle 2: reg_sel=2, r_out, z_in, alu_op=00011.
  - cycle 3: zlo_out, reg_sel=3, r_in, done.
  - cycle 4: op_ready=1.
- NOT 10010, ra=5, rd=6. Required response: no y_in ever; cycle 1 reg_sel=5, z_in; cycle 2 r_in to reg 6, done.
- MUL 01111 with MULDIV_LAT=3. Required response:
  - EXEC lasts cycles 2–4, with z_in only in cycle 4.
  - cycle 5: zlo_out+lo_in.
  - cycle 6: zhi_out+hi_in+done. r_in never asserted.
- Illegal opcode 11111. Required response: illegal=1 in cycle 1 only, all strobes 0, op_ready=1 in cycle 2.
- clr=1 during the second EXEC cycle of a DIV. Required response: next cycle all outputs 0 and IDLE; lo_in/hi_in/done never assert. A subsequent SUB executes normally.
- op_valid held high with SUB then AND. Required response: AND accepted in the IDLE cycle right after SUB's done; the two instructions' strobes never overlap.
